// File: rtl/frac_mult_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frac_mult_pipe: 3-stage signed data x Q1.(CW-1) coefficient multiplier    |
// | with truncate/round, saturation flag/count and valid/ready flow control.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module frac_mult_pipe #(
  parameter int DW   = 17,
  parameter int CW   = 8,
  parameter int TW   = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [CW-1:0]   in_coef,
  input  logic            in_rnd,
  input  logic [TW-1:0]   in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_sat,
  output logic [TW-1:0]   out_tag,
  output logic [CNTW-1:0] sat_cnt,
  input  logic            sat_clr
);

  localparam int c_pw = DW + CW;
  localparam int c_sw = c_pw + 1;
  localparam logic [c_sw-1:0] c_half = c_sw'(1) << (CW - 2);
  localparam logic [DW-1:0]   c_max  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]   c_min  = {1'b1, {(DW-1){1'b0}}};

  logic w_stall;
  logic w_advance;

  logic          r_s1_valid;
  logic [DW-1:0] r_s1_data;
  logic [CW-1:0] r_s1_coef;
  logic          r_s1_rnd;
  logic [TW-1:0] r_s1_tag;

  logic                   r_s2_valid;
  logic signed [c_pw-1:0] r_s2_prod;
  logic                   r_s2_rnd;
  logic [TW-1:0]          r_s2_tag;

  logic signed [c_pw-1:0] w_prod;
  logic [c_sw-1:0]        w_sum;
  logic [c_sw-1:0]        w_shift;
  logic [c_sw-DW:0]       w_hi;
  logic                   w_fits;
  logic [DW-1:0]          w_data;

  // The whole pipe freezes while the output register holds an unaccepted sample.
  assign w_stall   = out_valid & ~out_ready;
  assign w_advance = ~w_stall;
  assign in_ready  = rst_n & ~w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_coef  <= '0;
      r_s1_rnd   <= 1'b0;
      r_s1_tag   <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_coef <= in_coef;
        r_s1_rnd  <= in_rnd;
        r_s1_tag  <= in_tag;
      end
    end
  end

  assign w_prod = $signed({{CW{r_s1_data[DW-1]}}, r_s1_data})
                * $signed({{DW{r_s1_coef[CW-1]}}, r_s1_coef});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_rnd   <= 1'b0;
      r_s2_tag   <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_prod <= w_prod;
        r_s2_rnd  <= r_s1_rnd;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  // One guard bit above the product keeps the rounding add from wrapping.
  assign w_sum   = {r_s2_prod[c_pw-1], r_s2_prod} + (r_s2_rnd ? c_half : '0);
  assign w_shift = $signed(w_sum) >>> (CW - 1);
  assign w_hi    = w_shift[c_sw-1:DW-1];
  assign w_fits  = (&w_hi) | ~(|w_hi);
  assign w_data  = w_fits ? w_shift[DW-1:0] : (w_shift[c_sw-1] ? c_min : c_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_tag   <= '0;
    end else if (w_advance) begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        out_data <= w_data;
        out_sat  <= ~w_fits;
        out_tag  <= r_s2_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && out_sat && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
